// File: rtl/front_end_arb.sv
// Round-robin front-end: N_CH native requesters share one cache data port and one cache-control port.
// state | meaning -- IDLE: arbitrating, no request outstanding; BUSY: granted request held downstream
module front_end_arb #(
  parameter int  FE_ADDR_W   = 32,
  parameter int  FE_DATA_W   = 32,
  parameter int  N_CH        = 2,
  parameter int  CTRL_CACHE  = 0,
  parameter int  CTRL_ADDR_W = 4,
  localparam int FE_NBYTES   = FE_DATA_W / 8,
  localparam int FE_BYTE_W   = $clog2(FE_NBYTES),
  localparam int AW          = CTRL_CACHE + FE_ADDR_W
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_CH-1:0]                ch_valid_i,
  input  logic [N_CH*AW-1:0]             ch_addr_i,
  input  logic [N_CH*FE_DATA_W-1:0]      ch_wdata_i,
  input  logic [N_CH*FE_NBYTES-1:0]      ch_wstrb_i,
  output logic [N_CH-1:0]                ch_ready_o,
  output logic [N_CH*FE_DATA_W-1:0]      ch_rdata_o,
  output logic                           data_valid_o,
  output logic [FE_ADDR_W-FE_BYTE_W-1:0] data_addr_o,
  output logic [FE_DATA_W-1:0]           data_wdata_o,
  output logic [FE_NBYTES-1:0]           data_wstrb_o,
  input  logic [FE_DATA_W-1:0]           data_rdata_i,
  input  logic                           data_ready_i,
  output logic                           ctrl_valid_o,
  output logic [CTRL_ADDR_W-1:0]         ctrl_addr_o,
  input  logic [FE_DATA_W-1:0]           ctrl_rdata_i,
  input  logic                           ctrl_ready_i
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WA_W  = FE_ADDR_W - FE_BYTE_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d, rr_last_q, rr_last_d;
  logic [WA_W-1:0]      waddr_q, waddr_d;
  logic [FE_DATA_W-1:0] wdata_q, wdata_d;
  logic [FE_NBYTES-1:0] wstrb_q, wstrb_d;
  logic                 is_ctrl_q, is_ctrl_d;
  logic                 data_valid_q, data_valid_d;
  logic                 ctrl_valid_q, ctrl_valid_d;

  logic [AW-1:0]        addr_a  [N_CH];
  logic [FE_DATA_W-1:0] wdata_a [N_CH];
  logic [FE_NBYTES-1:0] wstrb_a [N_CH];
  logic [SEL_W-1:0]     grant;
  logic                 any_req;
  logic                 done;
  logic [FE_DATA_W-1:0] rsp_rdata;
  logic                 unused_addr_bits;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      addr_a[i]  = ch_addr_i[i*AW +: AW];
      wdata_a[i] = ch_wdata_i[i*FE_DATA_W +: FE_DATA_W];
      wstrb_a[i] = ch_wstrb_i[i*FE_NBYTES +: FE_NBYTES];
    end
  end

  // Channels above rr_last outrank those at or below it; within each group the lowest index wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (ch_valid_i[i] && (i <= int'(rr_last_q))) begin
        grant   = SEL_W'(i);
        any_req = 1'b1;
      end
    end
    for (int i = N_CH-1; i >= 0; i--) begin
      if (ch_valid_i[i] && (i > int'(rr_last_q))) begin
        grant   = SEL_W'(i);
        any_req = 1'b1;
      end
    end
  end

  assign done      = (state_q == BUSY) && (is_ctrl_q ? ctrl_ready_i : data_ready_i);
  assign rsp_rdata = is_ctrl_q ? ctrl_rdata_i : data_rdata_i;

  always_comb begin
    ch_ready_o = '0;
    ch_rdata_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (done && (sel_q == SEL_W'(i))) begin
        ch_ready_o[i]                         = 1'b1;
        ch_rdata_o[i*FE_DATA_W +: FE_DATA_W] = rsp_rdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_last_d    = rr_last_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    is_ctrl_d    = is_ctrl_q;
    data_valid_d = data_valid_q;
    ctrl_valid_d = ctrl_valid_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = BUSY;
          sel_d        = grant;
          rr_last_d    = grant;
          waddr_d      = addr_a[grant][FE_ADDR_W-1:FE_BYTE_W];
          wdata_d      = wdata_a[grant];
          wstrb_d      = wstrb_a[grant];
          is_ctrl_d    = (CTRL_CACHE != 0) && addr_a[grant][AW-1];
          data_valid_d = ~is_ctrl_d;
          ctrl_valid_d = is_ctrl_d;
        end
      end
      BUSY: begin
        if (done) begin
          state_d      = IDLE;
          data_valid_d = 1'b0;
          ctrl_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      rr_last_q    <= SEL_W'(N_CH-1);
      waddr_q      <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      is_ctrl_q    <= 1'b0;
      data_valid_q <= 1'b0;
      ctrl_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_last_q    <= rr_last_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      is_ctrl_q    <= is_ctrl_d;
      data_valid_q <= data_valid_d;
      ctrl_valid_q <= ctrl_valid_d;
    end
  end

  assign data_valid_o = data_valid_q;
  assign ctrl_valid_o = ctrl_valid_q;
  assign data_addr_o  = waddr_q;
  assign data_wdata_o = wdata_q;
  assign data_wstrb_o = wstrb_q;
  // Control registers sit in the low word-address bits of the latched request.
  assign ctrl_addr_o  = (CTRL_CACHE != 0) ? waddr_q[CTRL_ADDR_W-1:0] : '0;

  assign unused_addr_bits = ^ch_addr_i;

endmodule

// File: tb/tb_front_end_arb.sv
// Scoreboard bench for front_end_arb: directed scenarios followed by randomized traffic,
// checked against a request-level arbitration model and per-channel response queues.
module tb_front_end_arb;
  localparam int AW = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ch_valid;
  logic [65:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [7:0]  ch_wstrb;
  logic [1:0]  ch_ready;
  logic [63:0] ch_rdata;
  logic        data_valid;
  logic [29:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        ctrl_valid;
  logic [3:0]  ctrl_addr;
  logic [31:0] ctrl_rdata;
  logic        ctrl_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  front_end_arb #(
    .FE_ADDR_W(32), .FE_DATA_W(32), .N_CH(2), .CTRL_CACHE(1), .CTRL_ADDR_W(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ch_valid_i(ch_valid), .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata), .ch_wstrb_i(ch_wstrb),
    .ch_ready_o(ch_ready), .ch_rdata_o(ch_rdata),
    .data_valid_o(data_valid), .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_wstrb_o(data_wstrb), .data_rdata_i(data_rdata), .data_ready_i(data_ready),
    .ctrl_valid_o(ctrl_valid), .ctrl_addr_o(ctrl_addr), .ctrl_rdata_i(ctrl_rdata),
    .ctrl_ready_i(ctrl_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream responders return data derived from the address they are shown.
  function automatic logic [31:0] fd(input logic [29:0] a);
    return {a[15:0], a[29:14]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] fc(input logic [3:0] a);
    return {8{a}} ^ 32'h0F0F_1234;
  endfunction

  task automatic set_req(input int c, input logic [32:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] exp_rd);
    ch_valid[c]          = 1'b1;
    ch_addr[c*AW +: AW]  = a;
    ch_wdata[c*32 +: 32] = wd;
    ch_wstrb[c*4 +: 4]   = ws;
    if (c == 0) exp_q0.push_back(exp_rd);
    else        exp_q1.push_back(exp_rd);
  endtask

  task automatic rand_req(input int c);
    logic [32:0] a;
    logic [3:0]  ws;
    a  = {($urandom_range(0, 2) == 0), 32'($urandom)};
    ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    set_req(c, a, $urandom, ws, a[32] ? fc(a[5:2]) : fd(a[31:2]));
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!(data_valid || ctrl_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("wait_busy", {63'd0, data_valid | ctrl_valid}, 64'd1);
  endtask

  // Request-level model: one outstanding request, round-robin from the last grant.
  int          m_busy = 0;
  int          m_rr   = 1;
  int          m_sel  = 0;
  int          m_c;
  logic [32:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0;
      m_rr   = 1;
      check("rst_ctl", {ch_ready, data_valid, ctrl_valid, ctrl_addr, data_wstrb}, 64'd0);
      check("rst_req", {data_addr, data_wdata}, 64'd0);
      check("rst_rdata", ch_rdata, 64'd0);
    end else if (m_busy != 0) begin
      check("m_data_valid", data_valid, !m_addr[32]);
      check("m_ctrl_valid", ctrl_valid, m_addr[32]);
      if (m_addr[32]) begin
        check("m_ctrl_addr", ctrl_addr, m_addr[5:2]);
      end else begin
        check("m_data_addr", data_addr, m_addr[31:2]);
        check("m_wdata", data_wdata, m_wdata);
        check("m_wstrb", data_wstrb, m_wstrb);
      end
      m_done = m_addr[32] ? ctrl_ready : data_ready;
      check("m_ch_ready", ch_ready, m_done ? (64'd1 << m_sel) : 64'd0);
      if (m_done) m_busy = 0;
    end else begin
      check("m_idle_quiet", {data_valid, ctrl_valid, ch_ready}, 64'd0);
      for (int i = 1; i <= 2; i++) begin
        m_c = (m_rr + i) % 2;
        if (m_busy == 0 && ch_valid[m_c]) begin
          m_busy  = 1;
          m_sel   = m_c;
          m_rr    = m_c;
          m_addr  = ch_addr[m_c*AW +: AW];
          m_wdata = ch_wdata[m_c*32 +: 32];
          m_wstrb = ch_wstrb[m_c*4 +: 4];
        end
      end
    end
  end

  logic [31:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && ch_ready != 2'b00) begin
      if (ch_ready == 2'b01) begin
        if (exp_q0.size() == 0) check("rsp_unexpected_ch0", ch_ready, 64'd0);
        else begin
          mon_e = exp_q0.pop_front();
          check("rsp_rdata_ch0", ch_rdata[31:0], mon_e);
          check("rsp_idle_ch1", ch_rdata[63:32], 64'd0);
        end
      end else if (ch_ready == 2'b10) begin
        if (exp_q1.size() == 0) check("rsp_unexpected_ch1", ch_ready, 64'd0);
        else begin
          mon_e = exp_q1.pop_front();
          check("rsp_rdata_ch1", ch_rdata[63:32], mon_e);
          check("rsp_idle_ch0", ch_rdata[31:0], 64'd0);
        end
      end else begin
        check("rsp_onehot", ch_ready, 64'd1);
      end
    end
  end

  logic [1:0] rdy;
  int         pulses;

  initial begin
    rst_n = 1'b0; ch_valid = '0; ch_addr = '0; ch_wdata = '0; ch_wstrb = '0;
    data_rdata = '0; data_ready = 1'b0; ctrl_rdata = '0; ctrl_ready = 1'b0;

    // Reset with both channels requesting, then ch0 first and strict alternation.
    set_req(0, 33'h0_0000_0400, 32'h0, 4'h0, fd(30'h100));
    set_req(1, 33'h0_0000_0800, 32'h0, 4'h0, fd(30'h200));
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("t1_no_valid_yet", data_valid, 64'd0);
    @(negedge clk); check("t1_valid_next", data_valid, 64'd1);
    check("t1_grant_ch0", data_addr, 64'h100);
    for (int g = 0; g < 6; g++) begin
      wait_busy();
      @(posedge clk); #1 data_ready = 1'b1; data_rdata = fd(data_addr);
      @(negedge clk);
      check("t3_order", data_addr, (g % 2 == 0) ? 64'h100 : 64'h200);
      check("t3_ready", ch_ready, (g % 2 == 0) ? 64'd1 : 64'd2);
      @(posedge clk); #1 data_ready = 1'b0; data_rdata = '0;
      if (g < 4) begin
        if (g % 2 == 0) exp_q0.push_back(fd(30'h100));
        else            exp_q1.push_back(fd(30'h200));
      end else begin
        ch_valid[g % 2] = 1'b0;
      end
      @(negedge clk); check("t3_bubble", {data_valid, ctrl_valid}, 64'd0);
    end

    // Read with delayed completion, word address drops the byte offset.
    @(posedge clk); #1 set_req(0, 33'h0_0000_48D0, 32'h0, 4'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk); check("t2_data_addr", data_addr, 64'h1234);
    @(negedge clk); check("t2_wait", ch_ready, 64'd0);
    @(posedge clk); #1 data_ready = 1'b1; data_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t2_ch_ready", ch_ready, 64'd1);
    check("t2_rdata0", ch_rdata[31:0], 64'hDEAD_BEEF);
    check("t2_rdata1", ch_rdata[63:32], 64'd0);
    @(posedge clk); #1 data_ready = 1'b0; data_rdata = '0; ch_valid = '0;

    // Control-port request; data_ready must be ignored while control is selected.
    @(posedge clk); #1 set_req(1, {1'b1, 32'h0000_000C}, 32'h0, 4'h0, 32'h5);
    @(negedge clk);
    @(negedge clk);
    check("t4_ctrl_valid", ctrl_valid, 64'd1);
    check("t4_data_valid", data_valid, 64'd0);
    check("t4_ctrl_addr", ctrl_addr, 64'h3);
    @(posedge clk); #1 data_ready = 1'b1; data_rdata = 32'hBAD0_0000;
    @(negedge clk); check("t4_data_ready_ignored", ch_ready, 64'd0);
    @(posedge clk); #1 data_ready = 1'b0; ctrl_ready = 1'b1; ctrl_rdata = 32'h5;
    @(negedge clk);
    check("t4_ch_ready", ch_ready, 64'd2);
    check("t4_rdata1", ch_rdata[63:32], 64'h5);
    check("t4_rdata0", ch_rdata[31:0], 64'd0);
    @(posedge clk); #1 ctrl_ready = 1'b0; ctrl_rdata = '0; ch_valid = '0;

    // Long-stalled write: fields stable, exactly one completion pulse.
    @(posedge clk); #1 set_req(0, 33'h0_0000_0100, 32'h0102_0304, 4'b0011, 32'h1111_2222);
    pulses = 0;
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      check("t5_addr_strb", {data_valid, data_addr, data_wstrb}, {29'd0, 1'b1, 30'h40, 4'b0011});
      check("t5_wdata", data_wdata, 64'h0102_0304);
      pulses += int'(ch_ready[0]);
    end
    @(posedge clk); #1 data_ready = 1'b1; data_rdata = 32'h1111_2222;
    @(negedge clk); pulses += int'(ch_ready[0]);
    @(posedge clk); #1 data_ready = 1'b0; data_rdata = '0; ch_valid = '0;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(ch_ready[0]);
    end
    check("t5_single_pulse", 64'(pulses), 64'd1);

    // Reset while busy discards the request; afterwards ch0 has priority again.
    @(posedge clk); #1 set_req(0, 33'h0_0000_0200, 32'h0, 4'h0, fd(30'h80));
    @(negedge clk);
    @(negedge clk); check("t6_busy", data_valid, 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("t6_rst_drop", {data_valid, ctrl_valid, ch_ready}, 64'd0);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1; data_ready = 1'b1; data_rdata = fd(30'h80);
    set_req(0, 33'h0_0000_0200, 32'h0, 4'h0, fd(30'h80));
    set_req(1, 33'h0_0000_0300, 32'h0, 4'h0, fd(30'hC0));
    @(negedge clk); check("t6_no_pulse", ch_ready, 64'd0);
    @(negedge clk);
    check("t6_grant_ch0", data_addr, 64'h80);
    check("t6_ch0_done", ch_ready, 64'd1);
    @(posedge clk); #1 data_ready = 1'b0; data_rdata = '0; ch_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wait_busy();
    @(posedge clk); #1 data_ready = 1'b1; data_rdata = fd(data_addr);
    @(negedge clk); check("t6_ch1_done", ch_ready, 64'd2);
    @(posedge clk); #1 data_ready = 1'b0; data_rdata = '0; ch_valid = '0;

    // Randomized traffic with random downstream readiness on both ports.
    for (int cyc = 0; cyc < 3300; cyc++) begin
      @(negedge clk); rdy = ch_ready;
      @(posedge clk); #1;
      data_ready = ($urandom_range(0, 2) == 0);
      data_rdata = data_ready ? fd(data_addr) : $urandom;
      ctrl_ready = ($urandom_range(0, 2) == 0);
      ctrl_rdata = ctrl_ready ? fc(ctrl_addr) : $urandom;
      for (int c = 0; c < 2; c++) begin
        if (ch_valid[c] && rdy[c]) ch_valid[c] = 1'b0;
        if (cyc < 3000 && !ch_valid[c] && $urandom_range(0, 2) == 0) rand_req(c);
      end
    end
    check("drain_done", ch_valid, 64'd0);
    check("q0_empty", 64'(exp_q0.size()), 64'd0);
    check("q1_empty", 64'(exp_q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
